// File: rtl/tx_pkg.sv
// tx_pkg: shared encodings and field sizes for the PLCP transmit path.
// Rate codes and their data-bits-per-symbol live here for TX and RX reuse.
package tx_pkg;

    localparam int RATE_W  = 4;
    localparam int LEN_W   = 12;
    localparam int NDBPS_W = 8;
    localparam int DCNT_W  = 15;

    localparam int HDR_W  = 12;
    localparam int SIG_W  = 24;
    localparam int SVC_W  = 16;
    localparam int TAIL_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_SIGNAL,
        S_SERVICE,
        S_DATA,
        S_TAIL,
        S_PAD
    } tx_state_e;

    localparam logic [RATE_W-1:0] RATE_6M  = 4'b1101;
    localparam logic [RATE_W-1:0] RATE_9M  = 4'b1111;
    localparam logic [RATE_W-1:0] RATE_12M = 4'b0101;
    localparam logic [RATE_W-1:0] RATE_18M = 4'b0111;
    localparam logic [RATE_W-1:0] RATE_24M = 4'b1001;
    localparam logic [RATE_W-1:0] RATE_36M = 4'b1011;
    localparam logic [RATE_W-1:0] RATE_48M = 4'b0001;
    localparam logic [RATE_W-1:0] RATE_54M = 4'b0011;

    localparam logic [NDBPS_W-1:0] NDBPS_6M  = 8'd24;
    localparam logic [NDBPS_W-1:0] NDBPS_9M  = 8'd36;
    localparam logic [NDBPS_W-1:0] NDBPS_12M = 8'd48;
    localparam logic [NDBPS_W-1:0] NDBPS_18M = 8'd72;
    localparam logic [NDBPS_W-1:0] NDBPS_24M = 8'd96;
    localparam logic [NDBPS_W-1:0] NDBPS_36M = 8'd144;
    localparam logic [NDBPS_W-1:0] NDBPS_48M = 8'd192;
    localparam logic [NDBPS_W-1:0] NDBPS_54M = 8'd216;

    // SIGNAL word with even parity over rate, reserved bit and length.
    function automatic logic [SIG_W-1:0] signal_word(
        input logic [RATE_W-1:0] rate,
        input logic [LEN_W-1:0]  len
    );
        return {rate, 1'b0, len, ^{rate, len}, 6'b000000};
    endfunction

endpackage

// File: rtl/tx_controller_if.sv
// tx_controller_if: bundle of the frame-request, data and scrambler signals.
// The source/scrambler side uses master, the controller side uses slave.
interface tx_controller_if;
    import tx_pkg::*;

    logic              start;
    logic [RATE_W-1:0] rate;
    logic [LEN_W-1:0]  length;
    logic              data;
    logic              data_req;
    logic              scmb_out;
    logic              scmb_in;
    logic              scmb_sen;
    logic              dout;
    logic              valid;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, rate, length, data, scmb_out,
        input  data_req, scmb_in, scmb_sen,
        input  dout, valid, busy, done, err
    );

    modport slave (
        input  start, rate, length, data, scmb_out,
        output data_req, scmb_in, scmb_sen,
        output dout, valid, busy, done, err
    );

endinterface

// File: rtl/tx_rate_dec.sv
// tx_rate_dec: RATE code to data bits per OFDM symbol, with a valid flag.
// Purely combinational so the receive side can share it.
module tx_rate_dec
    import tx_pkg::*;
(
    input  logic [RATE_W-1:0]  rate_i,
    output logic [NDBPS_W-1:0] ndbps_o,
    output logic               valid_o
);

    // Table lookup; unknown codes decode to zero and are flagged invalid.
    always_comb begin
        ndbps_o = '0;
        valid_o = 1'b1;
        case (rate_i)
            RATE_6M:  ndbps_o = NDBPS_6M;
            RATE_9M:  ndbps_o = NDBPS_9M;
            RATE_12M: ndbps_o = NDBPS_12M;
            RATE_18M: ndbps_o = NDBPS_18M;
            RATE_24M: ndbps_o = NDBPS_24M;
            RATE_36M: ndbps_o = NDBPS_36M;
            RATE_48M: ndbps_o = NDBPS_48M;
            RATE_54M: ndbps_o = NDBPS_54M;
            default:  valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/tx_controller.sv
// tx_controller: PLCP transmit sequencer with an external scrambler.
// Emits HEADER, SIGNAL, SERVICE, DATA, TAIL and PAD one bit per cycle.
module tx_controller
    import tx_pkg::*;
#(
    parameter logic [HDR_W-1:0] HEADER       = 12'hFFF,
    parameter logic [SVC_W-1:0] SERVICE_INIT = 16'h5D00
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic [RATE_W-1:0] iRate,
    input  logic [LEN_W-1:0]  iLength,
    input  logic              iData,
    output logic              oDataReq,
    input  logic              iSCMB_Out,
    output logic              oSCMB_In,
    output logic              oSCMB_SEN,
    output logic              oData,
    output logic              oValid,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    localparam logic [4:0] HDR_LAST  = 5'(HDR_W - 1);
    localparam logic [4:0] SIG_LAST  = 5'(SIG_W - 1);
    localparam logic [4:0] SVC_LAST  = 5'(SVC_W - 1);
    localparam logic [4:0] TAIL_LAST = 5'(TAIL_W - 1);

    tx_state_e          state_q;
    logic [RATE_W-1:0]  rate_q;
    logic [LEN_W-1:0]   len_q;
    logic [NDBPS_W-1:0] ndbps_q;
    logic [4:0]         fcnt_q;
    logic [DCNT_W-1:0]  dcnt_q;
    logic [NDBPS_W-1:0] sym_q;
    logic               data_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [NDBPS_W-1:0] dec_ndbps;
    logic               dec_valid;
    logic [SIG_W-1:0]   sig_w;
    logic               sym_wrap;
    logic [NDBPS_W-1:0] sym_d;

    tx_rate_dec u_rate_dec (
        .rate_i  (iRate),
        .ndbps_o (dec_ndbps),
        .valid_o (dec_valid)
    );

    assign sig_w    = signal_word(rate_q, len_q);
    assign sym_wrap = (sym_q == ndbps_q - 8'd1);
    assign sym_d    = sym_wrap ? '0 : sym_q + 8'd1;

    assign oData  = data_q;
    assign oValid = valid_q;
    assign oBusy  = busy_q;
    assign oDone  = done_q;
    assign oErr   = err_q;

    // Data request and scrambler feed follow the current state directly.
    always_comb begin
        oDataReq  = 1'b0;
        oSCMB_SEN = 1'b0;
        oSCMB_In  = 1'b0;
        case (state_q)
            S_SERVICE: begin
                oSCMB_SEN = 1'b1;
                oSCMB_In  = SERVICE_INIT[fcnt_q[3:0]];
            end
            S_DATA: begin
                oDataReq = 1'b1;
                oSCMB_In = iData;
            end
            default: ;
        endcase
    end

    // Frame sequencer; busy holds through the done cycle so a new start
    // is only taken once busy has dropped.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            rate_q  <= '0;
            len_q   <= '0;
            ndbps_q <= '0;
            fcnt_q  <= '0;
            dcnt_q  <= '0;
            sym_q   <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (done_q) busy_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (iStart && !busy_q) begin
                        if (dec_valid && iLength != '0) begin
                            rate_q  <= iRate;
                            len_q   <= iLength;
                            ndbps_q <= dec_ndbps;
                            fcnt_q  <= HDR_LAST;
                            busy_q  <= 1'b1;
                            state_q <= S_HEADER;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_HEADER: begin
                    data_q  <= HEADER[fcnt_q[3:0]];
                    valid_q <= 1'b1;
                    if (fcnt_q == '0) begin
                        fcnt_q  <= SIG_LAST;
                        state_q <= S_SIGNAL;
                    end else begin
                        fcnt_q <= fcnt_q - 5'd1;
                    end
                end
                S_SIGNAL: begin
                    data_q  <= sig_w[fcnt_q];
                    valid_q <= 1'b1;
                    if (fcnt_q == '0) begin
                        fcnt_q  <= SVC_LAST;
                        sym_q   <= '0;
                        state_q <= S_SERVICE;
                    end else begin
                        fcnt_q <= fcnt_q - 5'd1;
                    end
                end
                S_SERVICE: begin
                    data_q  <= SERVICE_INIT[fcnt_q[3:0]];
                    valid_q <= 1'b1;
                    sym_q   <= sym_d;
                    if (fcnt_q == '0) begin
                        dcnt_q  <= {len_q, 3'b000} - 15'd1;
                        state_q <= S_DATA;
                    end else begin
                        fcnt_q <= fcnt_q - 5'd1;
                    end
                end
                S_DATA: begin
                    data_q  <= iSCMB_Out;
                    valid_q <= 1'b1;
                    sym_q   <= sym_d;
                    if (dcnt_q == '0) begin
                        fcnt_q  <= TAIL_LAST;
                        state_q <= S_TAIL;
                    end else begin
                        dcnt_q <= dcnt_q - 15'd1;
                    end
                end
                S_TAIL: begin
                    data_q  <= 1'b0;
                    valid_q <= 1'b1;
                    sym_q   <= sym_d;
                    if (fcnt_q == '0) begin
                        if (sym_wrap) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_PAD;
                        end
                    end else begin
                        fcnt_q <= fcnt_q - 5'd1;
                    end
                end
                S_PAD: begin
                    data_q  <= iSCMB_Out;
                    valid_q <= 1'b1;
                    sym_q   <= sym_d;
                    if (sym_wrap) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tx_controller.md
TX_CONTROLLER -- requirements
Module: tx_controller

Interface
REQ-001 SHALL have parameter HEADER, default 12'hFFF, PLCP preamble sent MSB first.
REQ-002 SHALL have parameter SERVICE_INIT, default 16'h5D00, SERVICE field sent MSB first; it also seeds the scrambler.
REQ-003 SHALL have ports: iClk  in  1  clock; iRst_n  in  1  reset.
REQ-004 SHALL have ports: iStart  in  1  frame start request; iRate  in  4  RATE code; iLength  in  12  PSDU length in bytes.
REQ-005 SHALL have ports: iData  in  1  raw data bit; oDataReq  out  1  data bit consumed this cycle.
REQ-006 SHALL have ports: iSCMB_Out  in  1  scrambler output; oSCMB_In  out  1  scrambler input; oSCMB_SEN  out  1  scrambler set-seed enable.
REQ-007 SHALL have ports: oData  out  1  serial TX stream; oValid  out  1  oData valid; oBusy  out  1  frame in progress; oDone  out  1  last-bit pulse; oErr  out  1  rejected-start pulse.
REQ-008 SHALL use one clock, iClk; reset iRst_n SHALL be asynchronous and active-low.

Function
REQ-009 SHALL implement states IDLE, HEADER, SIGNAL, SERVICE, DATA, TAIL, PAD.
REQ-010 In IDLE, iStart=1 with valid iRate and iLength in 1..4095 SHALL latch RATE, LENGTH and N_DBPS, and go to HEADER next cycle.
REQ-011 In IDLE, iStart=1 with an invalid RATE or iLength=0 SHALL stay in IDLE and pulse oErr for 1 cycle (registered, cycle after the request).
REQ-012 iStart outside IDLE SHALL be ignored, with no oErr.
REQ-013 N_DBPS decode: 1101->24, 1111->36, 0101->48, 0111->72, 1001->96, 1011->144, 0001->192, 0011->216; all other codes are invalid.
REQ-014 SIGNAL word SHALL be {RATE[3:0], 1'b0, LENGTH[11:0], P, 6'b0}, sent bit 23 first; P makes bits 23:6 even parity.
REQ-015 Bit counts SHALL be: HEADER 12, SIGNAL 24, SERVICE 16, DATA 8*LENGTH, TAIL 6; PAD runs until the SERVICE+DATA+TAIL+PAD total is a multiple of N_DBPS.
REQ-016 oData and oValid SHALL be registered, so a bit selected in state cycle k appears on oData at cycle k+1.
REQ-017 HEADER, SIGNAL, SERVICE and TAIL bits SHALL be sent unscrambled; TAIL bits are 0.
REQ-018 During SERVICE: oSCMB_SEN=1 and oSCMB_In=current SERVICE bit.
REQ-019 During DATA: oDataReq=1 (combinational), oSCMB_In=iData sampled that cycle, and oData<=iSCMB_Out.
REQ-020 During PAD: oSCMB_In=0 and oData<=iSCMB_Out.
REQ-021 Outside SERVICE and DATA, oSCMB_SEN=0 and oSCMB_In=0; outside DATA, oDataReq=0.
REQ-022 No back-pressure: the source SHALL supply one bit every DATA cycle.
REQ-023 Symbol counter SHALL reset to 0 at the first SERVICE bit, increment every SERVICE/DATA/TAIL/PAD bit, and wrap at N_DBPS-1.
REQ-024 If the symbol counter wraps on the last TAIL bit, PAD SHALL be skipped (zero-length PAD); otherwise PAD SHALL end on the bit where the counter equals N_DBPS-1.
REQ-025 The data bit counter SHALL be 15 bits wide, loaded with 8*LENGTH-1 and counting down to 0 with no overflow for LENGTH=4095.
REQ-026 oValid SHALL be 1 exactly for every oData bit of the frame, and oBusy SHALL be 1 from the cycle after acceptance through the last oData bit.
REQ-027 oDone SHALL be 1 together with the last oData bit; next cycle oBusy=0 and a new iStart SHALL be accepted.
REQ-028 Total frame SHALL be 12+24+16+8*LENGTH+6+PAD bits, with the first HEADER bit on oData 2 cycles after the iStart cycle.

Reset
REQ-029 iRst_n=0 SHALL, asynchronously and at any point including mid-frame, force IDLE and clear all counters and latched fields.
REQ-030 iRst_n=0 SHALL drive oData, oValid, oBusy, oDone, oErr, oDataReq, oSCMB_SEN and oSCMB_In to 0.

Structure
REQ-031 A shared package tx_pkg SHALL hold the state encoding, the RATE code constants, the N_DBPS table, and the field widths (12/24/16/6).
REQ-032 The RATE decode with its valid flag SHALL be a sub-module, tx_rate_dec, that is combinational and reusable by the RX side.

Verification
REQ-033 Rate 1101, LENGTH=1 -> 84 oValid bits; header FFF; SIGNAL 0xD00080 (P=0); 8 oDataReq cycles; PAD=18; oDone on bit 84.
REQ-034 Rate 1011, LENGTH=3 -> SIGNAL 0xB001C0 (P=1); PAD=98; oSCMB_SEN high for exactly 16 cycles.
REQ-035 iRate=4'b0000 or iLength=0 -> single oErr pulse, oBusy stays 0, no oValid.
REQ-036 iStart pulsed again mid-DATA -> ignored; frame length unchanged; back-to-back iStart accepted the cycle after oDone.
REQ-037 iRst_n low during DATA -> all outputs 0 immediately; next valid iStart yields a complete, correct frame.
REQ-038 Loopback into the RX receiver path with LENGTH=4095 at rate 0011 -> the receiver recovers all 32760 bits; the TX bit count matches REQ-028.
